// File: rtl/aes_pkg.sv
// Shared AES byte-serial definitions.
//   AES_BLOCK_BYTES : bytes per 128-bit state
//   aes_byte_t      : one state byte
//   bank_state_t    : occupancy of one 16-byte buffer bank
//   shift_rows_src  : for output position k (row k%4, col k/4) returns the input
//                     position that lands there under (Inv)ShiftRows.
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Column arithmetic is 2-bit, so the mod-4 wrap falls out of the width.
  function automatic logic [3:0] shift_rows_src(logic [3:0] k, logic inverse);
    logic [1:0] row;
    logic [1:0] col;
    logic [1:0] src_col;
    row = k[1:0];
    col = k[3:2];
    if (inverse) begin
      src_col = col - row;
    end else begin
      src_col = col + row;
    end
    return {src_col, row};
  endfunction

endpackage

// File: rtl/shift_rows_bank.sv
// One 16x8 block buffer with its occupancy state.
//   clk, rst (async, active-high), flush (sync clear of the state flag)
//   wr_en/wr_addr/wr_data : byte write in state order; addr 15 completes the block
//   rd_done               : last byte of the stored block was accepted downstream
//   rd_idx/rd_data        : read in output order; the row-shift map is applied here
//   state                 : EMPTY / FILLING / FULL
module shift_rows_bank
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  aes_byte_t   wr_data,
  input  logic        rd_done,
  input  logic [3:0]  rd_idx,
  output aes_byte_t   rd_data,
  output bank_state_t state
);

  aes_byte_t   mem [AES_BLOCK_BYTES];
  bank_state_t state_nxt;
  logic        wr_ok;

  // A FULL bank is never overwritten; the top relies on this to keep the
  // reader's block intact without a bypass path.
  assign wr_ok = wr_en & (state != BANK_FULL);

  // Storage: contents are don't-care while EMPTY, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[shift_rows_src(rd_idx, INVERSE)];

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BANK_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy next-state: fill, hold while full, free after the last read.
  always_comb begin
    state_nxt = state;
    case (state)
      BANK_EMPTY: begin
        if (wr_ok) begin
          state_nxt = (wr_addr == 4'd15) ? BANK_FULL : BANK_FILLING;
        end else begin
          state_nxt = BANK_EMPTY;
        end
      end
      BANK_FILLING: begin
        if (wr_ok && (wr_addr == 4'd15)) begin
          state_nxt = BANK_FULL;
        end else begin
          state_nxt = BANK_FILLING;
        end
      end
      BANK_FULL: begin
        if (rd_done) begin
          state_nxt = BANK_EMPTY;
        end else begin
          state_nxt = BANK_FULL;
        end
      end
      default: state_nxt = BANK_EMPTY;
    endcase
    if (flush) begin
      state_nxt = BANK_EMPTY;
    end else begin
      state_nxt = state_nxt;
    end
  end

endmodule

// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows with a ping-pong pair of 16-byte banks.
// Bytes enter in column-major state order and leave in row-shifted order.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous clear of both banks, pointers and counters
//   in_valid/in_ready/in_data    : input byte stream (ready while write bank not FULL)
//   out_valid/out_ready/out_data : output byte stream (valid while read bank FULL)
//   out_last   : marks the 16th byte of each output block
// INVERSE=1 gives InvShiftRows, INVERSE=0 the forward map (self-test pairing).
module inv_shift_rows_serial
  import aes_pkg::*;
#(
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last
);

  logic        wr_bank;
  logic        rd_bank;
  logic [3:0]  wr_cnt;
  logic [3:0]  rd_cnt;
  bank_state_t bank_state   [2];
  aes_byte_t   bank_rd_data [2];
  logic        in_fire;
  logic        out_fire;

  assign in_ready  = (bank_state[wr_bank] != BANK_FULL);
  assign out_valid = (bank_state[rd_bank] == BANK_FULL);
  assign out_last  = out_valid & (rd_cnt == 4'd15);
  // Gate data so stale bank contents never appear on an idle bus.
  assign out_data  = out_valid ? bank_rd_data[rd_bank] : 8'h00;

  // flush wins over both handshakes in the same cycle.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready & ~flush;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    shift_rows_bank #(
      .INVERSE (INVERSE)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .wr_en   (in_fire & (wr_bank == 1'(b))),
      .wr_addr (wr_cnt),
      .wr_data (in_data),
      .rd_done (out_fire & (rd_bank == 1'(b)) & (rd_cnt == 4'd15)),
      .rd_idx  (rd_cnt),
      .rd_data (bank_rd_data[b]),
      .state   (bank_state[b])
    );
  end

  // Write pointer: advance per accepted byte, switch bank after the 16th.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= 4'd0;
    end else if (flush) begin
      wr_bank <= 1'b0;
      wr_cnt  <= 4'd0;
    end else if (in_fire) begin
      wr_cnt <= wr_cnt + 4'd1;
      if (wr_cnt == 4'd15) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // Read pointer: advance per accepted output byte, switch bank after the 16th.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_bank <= 1'b0;
      rd_cnt  <= 4'd0;
    end else if (flush) begin
      rd_bank <= 1'b0;
      rd_cnt  <= 4'd0;
    end else if (out_fire) begin
      rd_cnt <= rd_cnt + 4'd1;
      if (rd_cnt == 4'd15) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
module tb_inv_shift_rows_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;

  // forward -> inverse self-test chain
  logic       c_flush = 1'b0;
  logic       c_in_valid = 1'b0;
  logic [7:0] c_in_data = 8'h00;
  logic       c_in_ready;
  logic       c_mid_valid, c_mid_ready, c_mid_last;
  logic [7:0] c_mid_data;
  logic       c_out_valid, c_out_last;
  logic       c_out_ready = 1'b0;
  logic [7:0] c_out_data;

  always #5 clk = ~clk;

  inv_shift_rows_serial #(.INVERSE(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  inv_shift_rows_serial #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_mid_valid), .out_ready(c_mid_ready), .out_data(c_mid_data), .out_last(c_mid_last)
  );

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_inv (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_mid_valid), .in_ready(c_mid_ready), .in_data(c_mid_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last)
  );

  int pass_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model + compare process ----------------
  logic [7:0] exp_q[$];    // bytes of completed blocks, already in output order
  logic [7:0] part_q[$];   // bytes of the block being received
  logic [8:0] got_q[$];    // {last,data} of every accepted output byte
  int         got_cyc[$];
  logic [7:0] c_q[$];      // chain: bytes entered, awaiting identical exit
  int         c_mid_n = 0;
  int         c_out_n = 0;
  int         cycle = 0;
  int         rst_cnt = 0;
  int         seen_rst_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  task automatic model_clear();
    exp_q.delete();
    part_q.delete();
    c_q.delete();
    c_mid_n = 0;
    c_out_n = 0;
    prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    cycle++;
    if (rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      seen_rst_cnt = rst_cnt;
      model_clear();
    end else begin
      if (rst_cnt != seen_rst_cnt) begin
        seen_rst_cnt = rst_cnt;
        model_clear();
      end
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_data_held", 32'(out_data), 32'(prev_data));
        check("stall_last_held", 32'(out_last), 32'(prev_last));
      end
      // A bank is free unless two whole blocks are still waiting to drain.
      check("in_ready", 32'(in_ready), 32'(((exp_q.size() + 15) / 16) < 2));
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("out_data", 32'(out_data), 32'(exp_q[0]));
        check("out_last", 32'(out_last), 32'((exp_q.size() % 16) == 1));
      end else begin
        check("out_last_idle", 32'(out_last), 32'd0);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
      prev_last  = out_last;
      if (flush) begin
        exp_q.delete();
        part_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          got_q.push_back({out_last, out_data});
          got_cyc.push_back(cycle);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
          part_q.push_back(in_data);
          if (part_q.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
              int r, c;
              r = k % 4;
              c = k / 4;
              exp_q.push_back(part_q[4 * ((c - r) & 3) + r]);
            end
            part_q.delete();
          end
        end
      end
      // chain: forward then inverse must reproduce the input stream
      if (c_in_valid && c_in_ready) c_q.push_back(c_in_data);
      if (c_mid_valid && c_mid_ready) begin
        check("chain_mid_last", 32'(c_mid_last), 32'((c_mid_n % 16) == 15));
        c_mid_n++;
      end
      if (c_out_valid && c_out_ready) begin
        if (c_q.size() == 0) check("chain_underflow", 32'(c_q.size()), 32'd1);
        else check("chain_data", 32'(c_out_data), 32'(c_q.pop_front()));
        check("chain_out_last", 32'(c_out_last), 32'((c_out_n % 16) == 15));
        c_out_n++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int   stall_waits = 0;
  logic main_done = 1'b0;
  logic chain_done = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("push_timeout", 32'(in_ready), 32'd1);
    stall_waits += n;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string nm);
    int t = 0;
    while (got_q.size() < n && t < 300) begin
      tick();
      t++;
    end
    check(nm, 32'(got_q.size() >= n), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", chk_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] t1_exp [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    logic [7:0] t4_exp [4] = '{8'h10, 8'h1D, 8'h1A, 8'h17};
    int base;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 1: single block 00..0F, latency and exact order
    out_ready = 1'b1;
    base = got_q.size();
    stall_waits = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t1_no_early_valid", 32'(out_valid), 32'd0);
      push(8'(i));
    end
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    wait_got(base + 16, "t1_count");
    if (got_q.size() >= base + 16) begin
      for (int k = 0; k < 16; k++) begin
        check("t1_byte", 32'(got_q[base + k][7:0]), 32'(t1_exp[k]));
        check("t1_last", 32'(got_q[base + k][8]), 32'(k == 15));
      end
    end

    // 2: three blocks back-to-back, no input stall, no output gap
    tick();
    base = got_q.size();
    stall_waits = 0;
    for (int i = 0; i < 48; i++) push(8'($urandom));
    wait_got(base + 48, "t2_count");
    check("t2_no_in_stall", 32'(stall_waits), 32'd0);
    if (got_q.size() >= base + 48)
      check("t2_no_gap", 32'(got_cyc[base + 47] - got_cyc[base]), 32'd47);

    // 3: output stalled 40 cycles while feeding three blocks
    tick();
    out_ready = 1'b0;
    base = got_q.size();
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          push(8'($urandom));
          if (i == 31) check("t3_in_ready_drop", 32'(in_ready), 32'd0);
        end
      end
      begin
        repeat (40) tick();
        out_ready = 1'b1;
      end
    join
    wait_got(base + 48, "t3_count");

    // 4: async reset mid-block discards everything
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'($urandom));
    for (int i = 0; i < 7; i++) push(8'($urandom));
    check("t4_pre_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    rst_cnt++;
    #1;
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_data", 32'(out_data), 32'd0);
    check("t4_rst_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    base = got_q.size();
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    wait_got(base + 16, "t4_count");
    repeat (20) tick();
    check("t4_no_stale", 32'(got_q.size()), 32'(base + 16));
    if (got_q.size() >= base + 4)
      for (int k = 0; k < 4; k++) check("t4_byte", 32'(got_q[base + k][7:0]), 32'(t4_exp[k]));

    // 5: flush together with 16th input byte and an output handshake
    out_ready = 1'b0;
    for (int i = 0; i < 31; i++) push(8'($urandom));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    flush     = 1'b1;
    check("t5_pre_in_ready", 32'(in_ready), 32'd1);
    check("t5_pre_out_valid", 32'(out_valid), 32'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    repeat (5) tick();
    check("t5_still_empty", 32'(out_valid), 32'd0);

    // 6: random traffic on the main unit and 200 blocks through fwd->inv
    fork
      begin
        for (int i = 0; i < 3200; i++) begin
          int n = 0;
          if ($urandom_range(3) == 0) tick();
          c_in_valid = 1'b1;
          c_in_data  = 8'($urandom);
          while (!c_in_ready && n < 400) begin
            tick();
            n++;
          end
          if (n >= 400) check("chain_push_timeout", 32'(c_in_ready), 32'd1);
          tick();
          c_in_valid = 1'b0;
        end
        chain_done = 1'b1;
      end
      begin
        for (int i = 0; i < 320; i++) begin
          if ($urandom_range(4) == 0) repeat ($urandom_range(3)) tick();
          push(8'($urandom));
        end
        main_done = 1'b1;
      end
      begin
        while (!main_done) begin
          out_ready = ($urandom_range(3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        while (!chain_done) begin
          c_out_ready = ($urandom_range(3) != 0);
          tick();
        end
        c_out_ready = 1'b1;
      end
    join
    begin
      int t = 0;
      while ((exp_q.size() != 0 || c_q.size() != 0) && t < 500) begin
        tick();
        t++;
      end
    end
    check("t6_main_drained", 32'(exp_q.size()), 32'd0);
    check("t6_chain_drained", 32'(c_q.size()), 32'd0);
    check("t6_chain_count", 32'(c_out_n), 32'd3200);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
